mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multicycle main control unit for the unpipelined MIPS core.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and drives all datapath enables.
- Produces the 6-bit opcode-style o_aluOp consumed directly by the downstream ALU control decoder; that decoder maps 0x08 to add, 0x04/0x05 to subtract, 0x00 to funct decode, and immediate opcodes to their operation.
- Adds a memory ready handshake and a sticky illegal-opcode trap.

Parameters:
- MEM_WAIT_EN, 1, 1 = FETCH/MEMREAD/MEMWRITE wait for i_memReady; 0 = i_memReady treated as constant 1.

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_opcode  input  6  IR[31:26]; valid and stable from DECODE until return to FETCH
- i_zero  input  1  ALU zero flag, combinational in the current cycle
- i_memReady  input  1  memory access completes this cycle
- o_pcWrite  output  1  PC load enable
- o_iorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- o_memRead  output  1  memory read strobe
- o_memWrite  output  1  memory write strobe
- o_irWrite  output  1  IR load enable
- o_regDst  output  1  write register select: 1 = rd, 0 = rt
- o_memToReg  output  1  writeback source: 1 = MDR, 0 = ALUOut
- o_regWrite  output  1  register file write enable
- o_aluSrcA  output  1  ALU A select: 0 = PC, 1 = rs
- o_aluSrcB  output  2  ALU B select: 00 = rt, 01 = const 4, 10 = immediate, 11 = sign-extended imm<<2
- o_immZext  output  1  zero-extend the immediate (ORI/XORI/ANDI)
- o_pcSrc  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- o_aluOp  output  6  opcode-style ALU operation code
- o_state  output  4  current state, for debug
- o_illegal  output  1  sticky illegal-opcode flag

Behaviour:
- Reset: async, asserted immediately. State = IDLE (0); every output 0, including o_illegal. First clock after deassertion: IDLE -> FETCH unconditionally.
- Outputs are Moore decode of the state register, except where noted. Every output not listed for a state is 0.
- Encoding: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXECUTE 7, ALUWB 8, BRANCH 9, IMMEXEC 10, IMMWB 11, JUMP 12, TRAP 13. Codes 14/15 -> IDLE.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=0x08, pcSrc=00. irWrite = pcWrite = i_memReady. Stay in FETCH until i_memReady, then -> DECODE.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=0x08 (branch target into ALUOut). Next state by i_opcode:
  - 0x23/0x2B -> MEMADR
  - 0x00 -> EXECUTE
  - 0x04/0x05 -> BRANCH
  - 0x08/0x09/0x0C/0x0D/0x0E/0x0F -> IMMEXEC
  - 0x02 -> JUMP
  - anything else -> TRAP
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=0x08. LW -> MEMREAD, SW -> MEMWRITE.
- MEMREAD: memRead=1, iorD=1. Hold until i_memReady, then -> MEMWB.
- MEMWB: regDst=0, memToReg=1, regWrite=1. -> FETCH.
- MEMWRITE: memWrite=1, iorD=1. Hold (memWrite stays 1) until i_memReady, then -> FETCH.
- EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=0x00. -> ALUWB.
- ALUWB: regDst=1, memToReg=0, regWrite=1. -> FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=i_opcode, pcSrc=01.
  - pcWrite = i_zero for 0x04, ~i_zero for 0x05 (Mealy on i_zero).
  - -> FETCH.
- IMMEXEC: aluSrcA=1, aluSrcB=10, aluOp=i_opcode; immZext=1 for 0x0C/0x0D/0x0E. -> IMMWB.
- IMMWB: regDst=0, memToReg=0, regWrite=1; immZext held from IMMEXEC. -> FETCH.
- JUMP: pcSrc=10, pcWrite=1. -> FETCH.
- TRAP: o_illegal=1, all strobes 0. Absorbing: only reset exits.
- Cycle counts with no memory wait:
  - LW: 5
  - SW: 4
  - R-type: 4
  - Immediate: 4
  - Branch: 3
  - J: 3
- Each memory wait cycle adds 1.
- Reset mid-instruction: outputs drop to 0 in the same cycle. Any pending memWrite/regWrite is abandoned; no partial writeback.
- Exclusivity: memRead and memWrite are never both 1. regWrite is never asserted in the same cycle as pcWrite.

Test Plan:
- Reset pulse during MEMWRITE, i_memReady=0 -> memWrite falls immediately; o_state=0; after release, 0 -> 1.
- LW (0x23), i_memReady=1 -> states 1,2,3,4,5,1. MEMWB asserts regWrite=1, memToReg=1, regDst=0. aluOp=0x08 in FETCH, DECODE and MEMADR.
- R-type (0x00), i_memReady low for 3 FETCH cycles -> irWrite=pcWrite=0 for 3 cycles, 1 on the 4th. Then states 2,7,8; EXECUTE aluOp=0x00; ALUWB regDst=1.
- BEQ (0x04) with i_zero=1 -> BRANCH pcWrite=1, pcSrc=01, aluOp=0x04. BNE (0x05) with i_zero=1 -> pcWrite=0, state back to FETCH.
- ORI (0x0D) -> IMMEXEC aluOp=0x0D, immZext=1 in IMMEXEC and IMMWB, regWrite=1 in IMMWB only. ADDI (0x08) -> immZext=0.
- Opcode 0x3F -> DECODE then TRAP (13); o_illegal=1 stays set over 10 cycles with all strobes 0; cleared only by i_rst.

Source files
------------

// File: rtl/mc_control_if.sv
// Control/datapath bundle for the multicycle MIPS main control unit.
// master = control FSM, slave = datapath side.
interface mc_control_if;
  logic [5:0] i_opcode;
  logic       i_zero;
  logic       i_memReady;
  logic       o_pcWrite;
  logic       o_iorD;
  logic       o_memRead;
  logic       o_memWrite;
  logic       o_irWrite;
  logic       o_regDst;
  logic       o_memToReg;
  logic       o_regWrite;
  logic       o_aluSrcA;
  logic [1:0] o_aluSrcB;
  logic       o_immZext;
  logic [1:0] o_pcSrc;
  logic [5:0] o_aluOp;
  logic [3:0] o_state;
  logic       o_illegal;

  modport master (
    input  i_opcode, i_zero, i_memReady,
    output o_pcWrite, o_iorD, o_memRead,
    output o_memWrite, o_irWrite, o_regDst,
    output o_memToReg, o_regWrite, o_aluSrcA,
    output o_aluSrcB, o_immZext, o_pcSrc,
    output o_aluOp, o_state, o_illegal
  );

  modport slave (
    output i_opcode, i_zero, i_memReady,
    input  o_pcWrite, o_iorD, o_memRead,
    input  o_memWrite, o_irWrite, o_regDst,
    input  o_memToReg, o_regWrite, o_aluSrcA,
    input  o_aluSrcB, o_immZext, o_pcSrc,
    input  o_aluOp, o_state, o_illegal
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle main control FSM: fetch/decode/execute/mem/writeback
// sequencing with memory-ready stalls and a sticky illegal-opcode trap.
module mc_control_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic          i_clk,
  input logic          i_rst,
  mc_control_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_IMMEXEC  = 4'd10,
    S_IMMWB    = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  state_t state;
  state_t state_nx;

  logic [5:0] op;
  logic rdy;
  logic is_lw;
  logic is_sw;
  logic is_rtype;
  logic is_br;
  logic is_imm;
  logic is_j;
  logic is_zext;

  assign op  = bus.i_opcode;
  assign rdy = MEM_WAIT_EN ? bus.i_memReady : 1'b1;

  assign is_lw    = (op == 6'h23);
  assign is_sw    = (op == 6'h2B);
  assign is_rtype = (op == 6'h00);
  assign is_br    = (op == 6'h04) || (op == 6'h05);
  assign is_j     = (op == 6'h02);
  assign is_zext  = (op == 6'h0C) || (op == 6'h0D)
                 || (op == 6'h0E);
  assign is_imm   = is_zext || (op == 6'h08)
                 || (op == 6'h09) || (op == 6'h0F);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE:     state_nx = S_FETCH;
      S_FETCH:    state_nx = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: state_nx = S_MEMADR;
          is_rtype:     state_nx = S_EXECUTE;
          is_br:        state_nx = S_BRANCH;
          is_imm:       state_nx = S_IMMEXEC;
          is_j:         state_nx = S_JUMP;
          default:      state_nx = S_TRAP;
        endcase
      end
      S_MEMADR:   state_nx = is_sw ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nx = rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_nx = S_FETCH;
      S_MEMWRITE: state_nx = rdy ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_nx = S_ALUWB;
      S_ALUWB:    state_nx = S_FETCH;
      S_BRANCH:   state_nx = S_FETCH;
      S_IMMEXEC:  state_nx = S_IMMWB;
      S_IMMWB:    state_nx = S_FETCH;
      S_JUMP:     state_nx = S_FETCH;
      S_TRAP:     state_nx = S_TRAP;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_pcWrite  = 1'b0;
    bus.o_iorD     = 1'b0;
    bus.o_memRead  = 1'b0;
    bus.o_memWrite = 1'b0;
    bus.o_irWrite  = 1'b0;
    bus.o_regDst   = 1'b0;
    bus.o_memToReg = 1'b0;
    bus.o_regWrite = 1'b0;
    bus.o_aluSrcA  = 1'b0;
    bus.o_aluSrcB  = 2'b00;
    bus.o_immZext  = 1'b0;
    bus.o_pcSrc    = 2'b00;
    bus.o_aluOp    = 6'h00;
    bus.o_illegal  = 1'b0;
    case (state)
      S_FETCH: begin
        bus.o_memRead = 1'b1;
        bus.o_aluSrcB = 2'b01;
        bus.o_aluOp   = 6'h08;
        bus.o_irWrite = rdy;
        bus.o_pcWrite = rdy;
      end
      S_DECODE: begin
        bus.o_aluSrcB = 2'b11;
        bus.o_aluOp   = 6'h08;
      end
      S_MEMADR: begin
        bus.o_aluSrcA = 1'b1;
        bus.o_aluSrcB = 2'b10;
        bus.o_aluOp   = 6'h08;
      end
      S_MEMREAD: begin
        bus.o_memRead = 1'b1;
        bus.o_iorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.o_memToReg = 1'b1;
        bus.o_regWrite = 1'b1;
      end
      S_MEMWRITE: begin
        bus.o_memWrite = 1'b1;
        bus.o_iorD     = 1'b1;
      end
      S_EXECUTE: begin
        bus.o_aluSrcA = 1'b1;
      end
      S_ALUWB: begin
        bus.o_regDst   = 1'b1;
        bus.o_regWrite = 1'b1;
      end
      S_BRANCH: begin
        // bne inverts the zero flag; beq uses it directly
        bus.o_aluSrcA = 1'b1;
        bus.o_aluOp   = op;
        bus.o_pcSrc   = 2'b01;
        bus.o_pcWrite = op[0] ? ~bus.i_zero : bus.i_zero;
      end
      S_IMMEXEC: begin
        bus.o_aluSrcA = 1'b1;
        bus.o_aluSrcB = 2'b10;
        bus.o_aluOp   = op;
        bus.o_immZext = is_zext;
      end
      S_IMMWB: begin
        bus.o_regWrite = 1'b1;
        bus.o_immZext  = is_zext;
      end
      S_JUMP: begin
        bus.o_pcSrc   = 2'b10;
        bus.o_pcWrite = 1'b1;
      end
      S_TRAP: begin
        bus.o_illegal = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.o_state = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed steps plus random instruction
// streams checked against an instruction-level reference model.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       src_a;
    logic [1:0] src_b;
    logic       imm_zext;
    logic [1:0] pc_src;
    logic [5:0] alu_op;
    logic       illegal;
  } ctl_t;

  typedef int q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;

  mc_control_if bus_if ();

  mc_control_fsm #(.MEM_WAIT_EN(1'b1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t got();
    ctl_t c;
    c.pc_write   = bus_if.o_pcWrite;
    c.ior_d      = bus_if.o_iorD;
    c.mem_read   = bus_if.o_memRead;
    c.mem_write  = bus_if.o_memWrite;
    c.ir_write   = bus_if.o_irWrite;
    c.reg_dst    = bus_if.o_regDst;
    c.mem_to_reg = bus_if.o_memToReg;
    c.reg_write  = bus_if.o_regWrite;
    c.src_a      = bus_if.o_aluSrcA;
    c.src_b      = bus_if.o_aluSrcB;
    c.imm_zext   = bus_if.o_immZext;
    c.pc_src     = bus_if.o_pcSrc;
    c.alu_op     = bus_if.o_aluOp;
    c.illegal    = bus_if.o_illegal;
    return c;
  endfunction

  // Instruction-level step lists, in the documented state numbering
  function automatic q_t path(input logic [5:0] op);
    q_t q;
    case (op)
      6'h23: q = '{1, 2, 3, 4, 5};
      6'h2B: q = '{1, 2, 3, 6};
      6'h00: q = '{1, 2, 7, 8};
      6'h04, 6'h05: q = '{1, 2, 9};
      6'h08, 6'h09, 6'h0C,
      6'h0D, 6'h0E, 6'h0F: q = '{1, 2, 10, 11};
      6'h02: q = '{1, 2, 12};
      default: q = '{1, 2, 13};
    endcase
    return q;
  endfunction

  function automatic ctl_t exp_ctl(input int st, input logic [5:0] op,
                                   input logic z, input logic rdy);
    ctl_t c;
    logic zx;
    c = '0;
    zx = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
    case (st)
      1: begin
        c.mem_read = 1; c.src_b = 2'b01; c.alu_op = 6'h08;
        c.ir_write = rdy; c.pc_write = rdy;
      end
      2: begin c.src_b = 2'b11; c.alu_op = 6'h08; end
      3: begin c.src_a = 1; c.src_b = 2'b10; c.alu_op = 6'h08; end
      4: begin c.mem_read = 1; c.ior_d = 1; end
      5: begin c.mem_to_reg = 1; c.reg_write = 1; end
      6: begin c.mem_write = 1; c.ior_d = 1; end
      7: begin c.src_a = 1; c.alu_op = 6'h00; end
      8: begin c.reg_dst = 1; c.reg_write = 1; end
      9: begin
        c.src_a = 1; c.alu_op = op; c.pc_src = 2'b01;
        c.pc_write = (op == 6'h04) ? z : !z;
      end
      10: begin
        c.src_a = 1; c.src_b = 2'b10; c.alu_op = op; c.imm_zext = zx;
      end
      11: begin c.reg_write = 1; c.imm_zext = zx; end
      12: begin c.pc_src = 2'b10; c.pc_write = 1; end
      13: c.illegal = 1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic check_cycle(input string tag, input int st,
                             input logic [5:0] op, input logic z,
                             input logic rdy);
    ctl_t g;
    g = got();
    chk({tag, "_state"}, 32'(bus_if.o_state), 32'(st));
    chk({tag, "_ctl"}, 32'(g), 32'(exp_ctl(st, op, z, rdy)));
    chk({tag, "_rdwr"}, 32'(g.mem_read & g.mem_write), 32'd0);
    chk({tag, "_regpc"}, 32'(g.reg_write & g.pc_write), 32'd0);
  endtask

  // Walks one instruction from FETCH; lows = forced FETCH stalls
  task automatic run_instr(input string tag, input logic [5:0] op,
                           input logic z, input int lows,
                           input bit rnd);
    q_t q;
    int st;
    int guard;
    logic rdy;
    q = path(op);
    guard = 0;
    bus_if.i_opcode = op;
    bus_if.i_zero = z;
    while (q.size() > 0) begin
      st = q[0];
      if (st == 1 && lows > 0) begin
        rdy = 1'b0;
        lows--;
      end else begin
        rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      bus_if.i_memReady = rdy;
      #1;
      check_cycle(tag, st, op, z, rdy);
      if (st == 13) q.delete();
      else if (!((st == 1 || st == 4 || st == 6) && !rdy))
        void'(q.pop_front());
      guard++;
      if (guard > 200) begin
        chk({tag, "_timeout"}, 32'(guard), 32'd0);
        q.delete();
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_rst_state"}, 32'(bus_if.o_state), 32'd0);
    chk({tag, "_rst_ctl"}, 32'(got()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk({tag, "_idle"}, 32'(bus_if.o_state), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_to_fetch"}, 32'(bus_if.o_state), 32'd1);
  endtask

  logic [5:0] ops [12] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08,
                           6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h02};

  initial begin
    bus_if.i_opcode = 6'h00;
    bus_if.i_zero = 1'b0;
    bus_if.i_memReady = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("por_state", 32'(bus_if.o_state), 32'd0);
    chk("por_ctl", 32'(got()), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("por_fetch", 32'(bus_if.o_state), 32'd1);

    // SW stuck in MEMWRITE, then reset mid-access
    bus_if.i_opcode = 6'h2B;
    bus_if.i_memReady = 1'b1;
    repeat (3) @(posedge clk);
    bus_if.i_memReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("sw_hold_state", 32'(bus_if.o_state), 32'd6);
    chk("sw_hold_wr", 32'(bus_if.o_memWrite), 32'd1);
    do_reset("sw_abort");
    chk("sw_abort_wr", 32'(bus_if.o_memWrite), 32'd0);

    run_instr("lw", 6'h23, 1'b0, 0, 1'b0);
    run_instr("rtype", 6'h00, 1'b0, 3, 1'b0);
    run_instr("beq", 6'h04, 1'b1, 0, 1'b0);
    run_instr("bne", 6'h05, 1'b1, 0, 1'b0);
    chk("bne_back", 32'(bus_if.o_state), 32'd1);
    run_instr("ori", 6'h0D, 1'b0, 0, 1'b0);
    run_instr("addi", 6'h08, 1'b0, 0, 1'b0);
    run_instr("j", 6'h02, 1'b0, 0, 1'b0);
    run_instr("sw", 6'h2B, 1'b0, 1, 1'b1);

    for (int i = 0; i < 60; i++) begin
      run_instr("rnd", ops[$urandom_range(0, 11)],
                1'($urandom_range(0, 1)), 0, 1'b1);
    end

    run_instr("ill", 6'h3F, 1'b0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus_if.i_opcode = 6'($urandom);
      bus_if.i_memReady = 1'($urandom);
      bus_if.i_zero = 1'($urandom);
      #1;
      check_cycle("trap", 13, bus_if.i_opcode, bus_if.i_zero, 1'b0);
      @(posedge clk);
      #1;
    end
    do_reset("trap_clr");
    chk("trap_clr_ill", 32'(bus_if.o_illegal), 32'd0);
    run_instr("post", 6'h00, 1'b0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
